// File: rtl/interconnect_link_pattern_sender_if.sv
// Multi-plane request/ack link: sender drives reqs, tag_lines and data_lines; receiver returns acks.
interface interconnect_link_if #(
  parameter int NUM_PLANES = 2,
  parameter int WORD_W     = 32,
  parameter int TAG_W      = 4
);
  logic [NUM_PLANES-1:0]             reqs;
  logic [NUM_PLANES-1:0]             acks;
  logic [NUM_PLANES-1:0][TAG_W-1:0]  tag_lines;
  logic [NUM_PLANES-1:0][WORD_W-1:0] data_lines;

  modport sender   (output reqs, tag_lines, data_lines, input acks);
  modport receiver (input reqs, tag_lines, data_lines, output acks);
endinterface

// File: rtl/interconnect_link_pattern_sender.sv
// Per-plane burst pattern sender over interconnect_link_if; data increments by default,
// or follows a Galois LFSR when TIA_LINK_PATTERN_LFSR_EN is defined.
module interconnect_link_pattern_sender #(
  parameter int TIA_NUM_PHYSICAL_PLANES = 2,
  parameter int TIA_WORD_WIDTH          = 32,
  parameter int TIA_TAG_WIDTH           = 4,
  parameter int NUM_PLANES              = TIA_NUM_PHYSICAL_PLANES,
  parameter int COUNT_WIDTH             = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_PLANES-1:0]                 start,
  input  logic [NUM_PLANES-1:0]                 abort,
  input  logic [NUM_PLANES*COUNT_WIDTH-1:0]     packet_count,
  input  logic [NUM_PLANES*TIA_WORD_WIDTH-1:0]  seed,
  input  logic [NUM_PLANES*TIA_TAG_WIDTH-1:0]   tag,
  output logic [NUM_PLANES-1:0]                 done,
  interconnect_link_if.sender                   interconnect_link
);

  localparam int W = TIA_WORD_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q     [NUM_PLANES];
  state_t                 state_d     [NUM_PLANES];
  logic [COUNT_WIDTH-1:0] remaining_q [NUM_PLANES];
  logic [COUNT_WIDTH-1:0] remaining_d [NUM_PLANES];
  logic [W-1:0]           word_q      [NUM_PLANES];
  logic [W-1:0]           word_d      [NUM_PLANES];
  logic [TIA_TAG_WIDTH-1:0] tag_q     [NUM_PLANES];
  logic [TIA_TAG_WIDTH-1:0] tag_d     [NUM_PLANES];

`ifdef TIA_LINK_PATTERN_LFSR_EN
  // Right-shift Galois masks of maximal-length polynomials; 32 bits is the fallback.
  localparam logic [63:0] TAPS64 = (W == 8)  ? 64'h00000000000000B8 :
                                   (W == 16) ? 64'h000000000000B400 :
                                   (W == 64) ? 64'hD800000000000000 :
                                               64'h0000000080200003;
  localparam logic [W-1:0] LFSR_TAPS = TAPS64[W-1:0];

  function automatic logic [W-1:0] next_word(input logic [W-1:0] w);
    return w[0] ? ((w >> 1) ^ LFSR_TAPS) : (w >> 1);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  function automatic logic [W-1:0] start_word(input logic [W-1:0] s);
    return (s == '0) ? W'(1) : s;
  endfunction
`else
  function automatic logic [W-1:0] next_word(input logic [W-1:0] w);
    return w + W'(1);
  endfunction

  function automatic logic [W-1:0] start_word(input logic [W-1:0] s);
    return s;
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < NUM_PLANES; i++) begin
      state_d[i]     = state_q[i];
      remaining_d[i] = remaining_q[i];
      word_d[i]      = word_q[i];
      tag_d[i]       = tag_q[i];
      case (state_q[i])
        SEND: begin
          if (interconnect_link.acks[i]) begin
            remaining_d[i] = remaining_q[i] - COUNT_WIDTH'(1);
            word_d[i]      = next_word(word_q[i]);
          end
          // An abort alongside an ack still consumes that packet, but the burst ends.
          if (abort[i]) begin
            state_d[i]     = IDLE;
            remaining_d[i] = '0;
          end else if (interconnect_link.acks[i] && remaining_q[i] == COUNT_WIDTH'(1)) begin
            state_d[i] = DONE;
          end
        end
        default: begin
          if (abort[i]) begin
            state_d[i] = IDLE;
          end else if (start[i]) begin
            remaining_d[i] = packet_count[i*COUNT_WIDTH +: COUNT_WIDTH];
            word_d[i]      = start_word(seed[i*W +: W]);
            tag_d[i]       = tag[i*TIA_TAG_WIDTH +: TIA_TAG_WIDTH];
            state_d[i]     = (packet_count[i*COUNT_WIDTH +: COUNT_WIDTH] == '0) ? DONE : SEND;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PLANES; i++) begin
      if (reset) begin
        state_q[i]     <= IDLE;
        remaining_q[i] <= '0;
      end else begin
        state_q[i]     <= state_d[i];
        remaining_q[i] <= remaining_d[i];
      end
    end
  end

  // Payload registers need no reset: they only reach the link while in SEND.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PLANES; i++) begin
      word_q[i] <= word_d[i];
      tag_q[i]  <= tag_d[i];
    end
  end

  always_comb begin
    done                         = '0;
    interconnect_link.reqs       = '0;
    interconnect_link.tag_lines  = '0;
    interconnect_link.data_lines = '0;
    for (int i = 0; i < NUM_PLANES; i++) begin
      done[i] = (state_q[i] == DONE);
      if (state_q[i] == SEND) begin
        interconnect_link.reqs[i]       = 1'b1;
        interconnect_link.tag_lines[i]  = tag_q[i];
        interconnect_link.data_lines[i] = word_q[i];
      end
    end
  end

endmodule

// File: tb/tb_interconnect_link_pattern_sender.sv
// Bench for interconnect_link_pattern_sender: directed bursts plus random traffic against a burst-list model.
module tb_interconnect_link_pattern_sender;

  localparam int NP = 2;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int CW = 16;
  localparam int MAXP = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     start, abort, done;
  logic [NP*CW-1:0]  packet_count;
  logic [NP*W-1:0]   seed;
  logic [NP*TW-1:0]  tag;

  interconnect_link_if #(.NUM_PLANES(NP), .WORD_W(W), .TAG_W(TW)) lnk ();

  interconnect_link_pattern_sender #(
    .TIA_NUM_PHYSICAL_PLANES(NP), .TIA_WORD_WIDTH(W), .TIA_TAG_WIDTH(TW),
    .NUM_PLANES(NP), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .packet_count(packet_count), .seed(seed), .tag(tag), .done(done),
    .interconnect_link(lnk)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the list of words each plane still owes the link, plus its done flag.
  logic [W-1:0]  exp_words [NP][MAXP];
  int            exp_len   [NP];
  int            exp_pos   [NP];
  logic [TW-1:0] exp_tag   [NP];
  logic          exp_done  [NP];

  function automatic logic [W-1:0] model_first(input logic [W-1:0] s);
`ifdef TIA_LINK_PATTERN_LFSR_EN
    if (s == 0) return 1;
`endif
    return s;
  endfunction

  function automatic logic [W-1:0] model_next(input logic [W-1:0] w);
`ifdef TIA_LINK_PATTERN_LFSR_EN
    logic [W-1:0] poly = 32'h80200003;
    logic [W-1:0] r = w >> 1;
    if (w[0]) r = r ^ poly;
    return r;
`else
    return w + 1;
`endif
  endfunction

  task automatic model_update();
    for (int i = 0; i < NP; i++) begin
      if (reset) begin
        exp_len[i] = 0; exp_pos[i] = 0; exp_done[i] = 1'b0;
      end else if (abort[i]) begin
        exp_len[i] = 0; exp_pos[i] = 0; exp_done[i] = 1'b0;
      end else if (exp_pos[i] < exp_len[i]) begin
        if (lnk.acks[i]) begin
          exp_pos[i]++;
          if (exp_pos[i] == exp_len[i]) exp_done[i] = 1'b1;
        end
      end else if (start[i]) begin
        int c = int'(packet_count[i*CW +: CW]);
        logic [W-1:0] w = model_first(seed[i*W +: W]);
        if (c > MAXP) c = MAXP;
        for (int k = 0; k < c; k++) begin
          exp_words[i][k] = w;
          w = model_next(w);
        end
        exp_len[i]  = c;
        exp_pos[i]  = 0;
        exp_tag[i]  = tag[i*TW +: TW];
        exp_done[i] = (c == 0);
      end
    end
  endtask

  task automatic check();
    for (int i = 0; i < NP; i++) begin
      logic          act   = exp_pos[i] < exp_len[i];
      logic [W-1:0]  edata = act ? exp_words[i][exp_pos[i]] : '0;
      logic [TW-1:0] etag  = act ? exp_tag[i] : '0;
      total++;
      assert (lnk.reqs[i] === act) else begin
        bad++; $error("FAIL reqs[%0d] observed=%b expected=%b t=%0t", i, lnk.reqs[i], act, $time);
      end
      total++;
      assert (lnk.data_lines[i] === edata) else begin
        bad++; $error("FAIL data[%0d] observed=%h expected=%h t=%0t", i, lnk.data_lines[i], edata, $time);
      end
      total++;
      assert (lnk.tag_lines[i] === etag) else begin
        bad++; $error("FAIL tag[%0d] observed=%h expected=%h t=%0t", i, lnk.tag_lines[i], etag, $time);
      end
      total++;
      assert (done[i] === exp_done[i]) else begin
        bad++; $error("FAIL done[%0d] observed=%b expected=%b t=%0t", i, done[i], exp_done[i], $time);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check();
  endtask

  task automatic set_plane(input int p, input int c, input logic [W-1:0] s, input logic [TW-1:0] t);
    packet_count[p*CW +: CW] = CW'(c);
    seed[p*W +: W]           = s;
    tag[p*TW +: TW]          = t;
    start[p]                 = 1'b1;
  endtask

  task automatic launch(input int p, input int c, input logic [W-1:0] s, input logic [TW-1:0] t);
    set_plane(p, c, s, t);
    step();
    start[p] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      exp_len[i] = 0; exp_pos[i] = 0; exp_tag[i] = '0; exp_done[i] = 1'b0;
    end
    reset = 1'b1; start = '0; abort = '0; packet_count = '0; seed = '0; tag = '0;
    lnk.acks = '0;
    step(); step();
    reset = 1'b0;
    step();

    // Four packets at full ack.
    lnk.acks = 2'b11;
    launch(0, 4, 32'h10, 4'd2);
    repeat (6) step();

    // Three packets with a toggling ack.
    launch(0, 3, 32'h200, 4'd7);
    for (int k = 0; k < 5; k++) begin
      lnk.acks[0] = (k % 2 == 0);
      step();
    end
    repeat (2) step();

    // Word wrap.
    lnk.acks = 2'b11;
    launch(0, 2, 32'hFFFF_FFFF, 4'd5);
    repeat (3) step();

    // Abort with the third ack, then a complete burst.
    launch(0, 5, 32'h40, 4'd3);
    step(); step();
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    repeat (2) step();
    launch(0, 5, 32'h80, 4'd9);
    repeat (6) step();

    // Zero-length burst on plane 1.
    launch(1, 0, 32'h1234, 4'd1);
    repeat (2) step();

    // Reset while both planes are mid-burst.
    set_plane(0, 8, 32'hA0, 4'd4);
    set_plane(1, 8, 32'hB0, 4'd6);
    step();
    start = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();

`ifdef TIA_LINK_PATTERN_LFSR_EN
    lnk.acks = 2'b11;
    launch(0, 16, 32'h1, 4'd8);
    repeat (18) step();
    launch(0, 3, 32'h0, 4'd8);
    repeat (4) step();
`endif

    // Random traffic on both planes.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NP; i++) begin
        start[i]                 = ($urandom_range(5) == 0);
        abort[i]                 = ($urandom_range(29) == 0);
        lnk.acks[i]              = ($urandom_range(3) != 0);
        packet_count[i*CW +: CW] = CW'($urandom_range(6));
        seed[i*W +: W]           = ($urandom_range(9) == 0) ? 32'hFFFF_FFFE : $urandom;
        tag[i*TW +: TW]          = TW'($urandom_range(15));
      end
      reset = ($urandom_range(149) == 0);
      step();
    end
    reset = 1'b0; start = '0; abort = '0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
